// File: rtl/l1_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module   : l1_bus_arb
//  Purpose  : Shares the single line-wide L2/memory port between the L1
//             instruction refill port and the L1 data port. Round-robin by
//             default; define ARB_DMEM_PRIO_EN for fixed D-over-I priority.
//  Revision : 1.0  initial release
// ============================================================================
module l1_bus_arb #(
    parameter int LINE_W = 256,
    parameter int BLK_W  = 59
) (
    input  logic              clk,
    input  logic              rst,
    // imem refill port
    input  logic [BLK_W-1:0]  b_addr_i,
    input  logic              b_rd_i,
    output logic [LINE_W-1:0] b_data_i,
    output logic              b_dv_i,
    // dmem port
    input  logic [BLK_W-1:0]  b_addr_d,
    input  logic              b_rd_d,
    input  logic              b_wr_d,
    input  logic [LINE_W-1:0] b_wdata_d,
    output logic [LINE_W-1:0] b_data_d,
    output logic              b_dv_d,
    // memory port
    output logic [BLK_W-1:0]  m_addr,
    output logic [LINE_W-1:0] m_wdata,
    output logic              m_we,
    output logic              m_req,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_ack
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BUSY_I = 2'd1;
    localparam logic [1:0] c_BUSY_D = 2'd2;

    logic [1:0] r_state;
    logic       w_req_i;
    logic       w_req_d;
    logic       w_grant_i;
    logic       w_grant_d;

    assign w_req_i = b_rd_i;
    assign w_req_d = b_rd_d | b_wr_d;

`ifdef ARB_DMEM_PRIO_EN
    assign w_grant_d = w_req_d;
    assign w_grant_i = w_req_i & ~w_req_d;
`else
    // r_last_d = 1 when the data side held the most recent grant
    logic r_last_d;

    assign w_grant_i = w_req_i & (~w_req_d | r_last_d);
    assign w_grant_d = w_req_d & (~w_req_i | ~r_last_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_d <= 1'b1;
        end else if (r_state == c_IDLE) begin
            if (w_grant_i)
                r_last_d <= 1'b0;
            else if (w_grant_d)
                r_last_d <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_grant_i) begin
                        r_state <= c_BUSY_I;
                        m_req   <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= b_addr_i;
                    end else if (w_grant_d) begin
                        r_state <= c_BUSY_D;
                        m_req   <= 1'b1;
                        m_we    <= b_wr_d;
                        m_addr  <= b_addr_d;
                        if (b_wr_d)
                            m_wdata <= b_wdata_d;
                    end
                end
                c_BUSY_I, c_BUSY_D: begin
                    // Memory-side fields stay frozen until the ack retires the transaction
                    if (m_ack) begin
                        r_state <= c_IDLE;
                        m_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    m_req   <= 1'b0;
                end
            endcase
        end
    end

    assign b_dv_i   = (r_state == c_BUSY_I) & m_ack;
    assign b_dv_d   = (r_state == c_BUSY_D) & m_ack;
    assign b_data_i = m_rdata;
    assign b_data_d = m_rdata;

endmodule
`default_nettype wire

// File: tb/tb_l1_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l1_bus_arb
//  Purpose  : Self-checking bench for l1_bus_arb; expected memory transactions
//             are queued when requests are driven and checked as they appear.
//  Revision : 1.0  initial release
// ============================================================================
module tb_l1_bus_arb;

    localparam int LINE_W = 256;
    localparam int BLK_W  = 59;

    typedef struct packed {
        logic              own_d;
        logic [BLK_W-1:0]  addr;
        logic              we;
        logic [LINE_W-1:0] wdata;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [BLK_W-1:0]  b_addr_i = '0;
    logic              b_rd_i = 1'b0;
    logic [LINE_W-1:0] b_data_i;
    logic              b_dv_i;
    logic [BLK_W-1:0]  b_addr_d = '0;
    logic              b_rd_d = 1'b0;
    logic              b_wr_d = 1'b0;
    logic [LINE_W-1:0] b_wdata_d = '0;
    logic [LINE_W-1:0] b_data_d;
    logic              b_dv_d;
    logic [BLK_W-1:0]  m_addr;
    logic [LINE_W-1:0] m_wdata;
    logic              m_we;
    logic              m_req;
    logic [LINE_W-1:0] m_rdata = '0;
    logic              m_ack = 1'b0;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    l1_bus_arb #(.LINE_W(LINE_W), .BLK_W(BLK_W)) u_dut (
        .clk(clk), .rst(rst),
        .b_addr_i(b_addr_i), .b_rd_i(b_rd_i), .b_data_i(b_data_i), .b_dv_i(b_dv_i),
        .b_addr_d(b_addr_d), .b_rd_d(b_rd_d), .b_wr_d(b_wr_d), .b_wdata_d(b_wdata_d),
        .b_data_d(b_data_d), .b_dv_d(b_dv_d),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_req(m_req),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic own_d, input logic [BLK_W-1:0] addr,
                        input logic we, input logic [LINE_W-1:0] wdata);
        exp_t e;
        e.own_d = own_d;
        e.addr  = addr;
        e.we    = we;
        e.wdata = wdata;
        sb.push_back(e);
    endtask

    // Wait for m_req, check it against the queue head, ack after lat cycles.
    // mode 1: disturb dmem inputs while busy; mode 2: drop all requests while busy.
    task automatic serve(input int lat, input int mode, input logic [LINE_W-1:0] rdata,
                         output int waited);
        exp_t e;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!m_req && waited < 20);
        if (!m_req) begin
            chk("req_timeout", {255'd0, m_req}, {255'd0, 1'b1});
            return;
        end
        if (sb.size() == 0) begin
            chk("sb_underflow", 256'd0, 256'd1);
            return;
        end
        e = sb.pop_front();
        chk("m_addr", m_addr, e.addr);
        chk("m_we", m_we, e.we);
        if (e.we) chk("m_wdata", m_wdata, e.wdata);
        for (int k = 0; k < lat; k++) begin
            if (k == 0) begin
                case (mode)
                    1: begin b_wdata_d = ~b_wdata_d; b_addr_d = b_addr_d + 1'b1; end
                    2: begin b_rd_i = 1'b0; b_rd_d = 1'b0; b_wr_d = 1'b0; end
                    default: ;
                endcase
            end
            tick();
        end
        chk("req_hold", m_req, 1);
        chk("addr_hold", m_addr, e.addr);
        if (e.we) chk("wdata_hold", m_wdata, e.wdata);
        m_rdata = rdata;
        m_ack   = 1'b1;
        #1;
        chk("dv_i", b_dv_i, !e.own_d);
        chk("dv_d", b_dv_d, e.own_d);
        if (!e.we) chk("rdata", e.own_d ? b_data_d : b_data_i, rdata);
        tick();
        m_ack = 1'b0;
        chk("req_drop", m_req, 0);
        chk("dv_after", {b_dv_i, b_dv_d}, 0);
    endtask

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [LINE_W-1:0] wd;

        // Reset state
        tick(); tick();
        chk("rst_m_req", m_req, 0);
        chk("rst_m_we", m_we, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_dv", {b_dv_i, b_dv_d}, 0);
        rst = 1'b0;

        // Spurious ack while idle
        tick();
        m_ack = 1'b1;
        #1;
        chk("spur_dv", {b_dv_i, b_dv_d}, 0);
        tick();
        m_ack = 1'b0;
        chk("spur_req", m_req, 0);

        // Simultaneous held requests
        b_addr_i = 59'h100; b_rd_i = 1'b1;
        b_addr_d = 59'h200; b_rd_d = 1'b1;
`ifdef ARB_DMEM_PRIO_EN
        for (int k = 0; k < 4; k++) push(1'b1, 59'h200, 1'b0, '0);
`else
        for (int k = 0; k < 2; k++) begin
            push(1'b0, 59'h100, 1'b0, '0);
            push(1'b1, 59'h200, 1'b0, '0);
        end
`endif
        for (int k = 0; k < 4; k++) serve(3, 0, rnd_line(), w);
        b_rd_i = 1'b0; b_rd_d = 1'b0;
        tick();

        // Single imem refill then back-to-back refill
        b_addr_i = 59'h40; b_rd_i = 1'b1;
        push(1'b0, 59'h40, 1'b0, '0);
        serve(3, 0, {32{8'hA5}}, w);
        chk("req_latency", w, 1);
        b_addr_i = 59'h80;
        push(1'b0, 59'h80, 1'b0, '0);
        serve(2, 0, rnd_line(), w);
        chk("b2b_gap", w, 1);
        b_rd_i = 1'b0;
        tick();

        // dmem writeback with inputs disturbed while busy
        wd = {8{32'hDEADBEEF}};
        b_addr_d = 59'h1234; b_wdata_d = wd; b_wr_d = 1'b1;
        push(1'b1, 59'h1234, 1'b1, wd);
        serve(3, 1, rnd_line(), w);
        b_wr_d = 1'b0;
        tick();

        // rd and wr both high counts as a write
        wd = rnd_line();
        b_addr_d = 59'h3C0; b_wdata_d = wd; b_rd_d = 1'b1; b_wr_d = 1'b1;
        push(1'b1, 59'h3C0, 1'b1, wd);
        serve(2, 0, rnd_line(), w);
        b_rd_d = 1'b0; b_wr_d = 1'b0;
        tick();

        // Requester withdraws while granted
        b_addr_d = 59'h55; b_rd_d = 1'b1;
        push(1'b1, 59'h55, 1'b0, '0);
        serve(4, 2, rnd_line(), w);
        tick();
        chk("withdraw_idle", m_req, 0);

        // Reset asserted mid-transaction
        b_addr_d = 59'h77; b_rd_d = 1'b1;
        tick(); tick();
        chk("busy_d_req", m_req, 1);
        #3;
        rst = 1'b1;
        m_ack = 1'b1;
        #1;
        chk("rst_async_req", m_req, 0);
        chk("rst_async_dv", {b_dv_i, b_dv_d}, 0);
        b_rd_d = 1'b0;
        tick();
        rst = 1'b0;
        m_ack = 1'b0;
        tick();
        chk("post_rst_req", m_req, 0);
        chk("post_rst_dv", {b_dv_i, b_dv_d}, 0);
        b_addr_i = 59'h300; b_rd_i = 1'b1;
        push(1'b0, 59'h300, 1'b0, '0);
        serve(2, 0, rnd_line(), w);
        b_rd_i = 1'b0;
        tick();

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/l1_bus_arb.md
Name: l1_bus_arb

Overview:
- Shares the single line-wide refill/writeback port to L2/memory between the L1 instruction cache refill port and the L1 data cache port.
- Round-robin arbitration; one transaction in flight at a time.
- Latches the granted address and write data, drives the memory request, and routes the data-valid pulse back to the owning cache.
- Sits between imem/dmem and the memory interface in the core top level.

Parameters:
LINE_W, 256, cache line width in bits (matches IMEM_LINE/DMEM_LINE)
BLK_W, 59, line (block) address width in bits (64 - log2(LINE_W/8))

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
b_addr_i  in  BLK_W  imem refill line address
b_rd_i  in  1  imem refill request, level; held until b_dv_i
b_data_i  out  LINE_W  refill data to imem; valid when b_dv_i
b_dv_i  out  1  imem completion pulse, 1 cycle
b_addr_d  in  BLK_W  dmem line address
b_rd_d  in  1  dmem line read request, level
b_wr_d  in  1  dmem line writeback request, level; mutually exclusive with b_rd_d
b_wdata_d  in  LINE_W  dmem writeback data
b_data_d  out  LINE_W  read data to dmem; valid when b_dv_d
b_dv_d  out  1  dmem completion pulse, 1 cycle
m_addr  out  BLK_W  memory line address
m_wdata  out  LINE_W  memory write data
m_we  out  1  1 = write, 0 = read
m_req  out  1  memory request, level; held until m_ack
m_rdata  in  LINE_W  memory read data; valid with m_ack
m_ack  in  1  memory completion pulse

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, b_dv_i=0, b_dv_d=0, last-grant pointer = D (so I wins first tie).
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Only the I request: go to BUSY_I.
  - Only a D request (b_rd_d|b_wr_d): go to BUSY_D.
  - Both: grant the requester not granted last.
  - On the transition edge, latch m_addr and m_we (b_wr_d for D, 0 for I); latch m_wdata from b_wdata_d for D writes.
  - Assert m_req registered, so m_req rises 1 cycle after a request is first seen in IDLE.
  - Update the last-grant pointer on grant.
- BUSY_x:
  - m_req, m_addr, m_we, m_wdata held constant.
  - Requester input changes are ignored.
  - On m_ack: b_dv_x=1 in the same cycle (combinational, gated by state); b_data_x = m_rdata.
  - Then m_req=0 and state=IDLE on the next edge.
- b_data_i and b_data_d always mirror m_rdata; consumers qualify with dv.
- Back-to-back transactions: the next grant is evaluated in the IDLE cycle after ack, so m_req is low for at least 1 cycle between transactions. Completed requesters drop rd the cycle after dv and do not re-request spuriously.
- Write completion: b_dv_d pulses on m_ack for writes too; b_data_d is don't-care.
- m_ack while IDLE: ignored, no dv pulse.
- b_rd_d and b_wr_d both high: treated as a write.
- Requester drops its request while granted: the transaction still completes and dv still pulses.
- Reset asserted mid-transaction: immediate return to IDLE, m_req=0, no dv. The memory side shares rst and abandons its transaction.
- No combinational path from any b_* request input to m_req.

Optional Feature:
- Macro: ARB_DMEM_PRIO_EN.
- Defined: fixed priority, D beats I on a tie; the last-grant pointer is not used (may be optimised away).
- Undefined: round-robin as above.
- Everything else is identical in both builds.

Test Plan:
- Single imem refill: b_rd_i=1, b_addr_i=0x40 at cycle 0 -> m_req=1, m_addr=0x40, m_we=0 at cycle 1; m_ack with m_rdata=0xA5..A5 at cycle 4 -> b_dv_i=1, b_data_i=0xA5..A5 at cycle 4 only; b_dv_d stays 0; m_req=0 at cycle 5.
- Simultaneous requests after reset: b_rd_i and b_rd_d held high, acks after 3 cycles each -> grant order I, D, I, D. With ARB_DMEM_PRIO_EN: D, D, ... and I is never granted while D is held.
- dmem writeback: b_wr_d=1, b_addr_d=0x1234, b_wdata_d=0xDEAD..BEEF -> m_we=1, m_wdata equals it; change b_wdata_d during BUSY -> m_wdata unchanged; b_dv_d pulses on ack.
- Spurious ack: m_ack=1 while IDLE -> no b_dv_i/b_dv_d, state stays IDLE.
- Reset mid-transaction: assert rst in BUSY_D between clock edges -> m_req=0 immediately without waiting for clk; no dv after release; a new b_rd_i request is granted normally.
- Back-to-back imem refills: b_rd_i re-asserted the cycle after b_dv_i -> m_req low for exactly 1 cycle, then high with the new address.
